// File: rtl/tx_frame_arbiter_pkg.sv
// Shared types and constants for the transmit frame-info arbiter.
package tx_arb_pkg;

    localparam int LEN_W = 11;
    localparam int TF_W  = LEN_W + 1;

    // The encoding is the src bit written into the frame-info FIFO.
    typedef enum logic {
        SRC_TC = 1'b0,
        SRC_DB = 1'b1
    } src_t;

endpackage

// File: rtl/tx_frame_arbiter_req_queue.sv
// Small synchronous FIFO holding pending frame lengths for one producer.
module req_queue #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign head   = mem[rdPtr];
    assign doPop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign doPush = push && (!full || doPop);

    // NOTE: the storage array is deliberately not reset; emptiness is decided
    // by the pointers and count alone, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Round-robin scheduler of db/tc transmit descriptors into the frame-info FIFO.
module tx_frame_arbiter #(
    parameter int LEN_W  = tx_arb_pkg::LEN_W,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             txStart_db,
    input  logic [LEN_W-1:0] txByteTotal_db,
    input  logic             txStart_tc,
    input  logic [LEN_W-1:0] txByteTotal_tc,
    input  logic             tfFifoFull,
    output logic [LEN_W:0]   tfFifoIn,
    output logic             tfWrEn,
    output logic             ovf_db,
    output logic             ovf_tc,
    output logic [15:0]      frames_db,
    output logic [15:0]      frames_tc,
    output logic             busy
);

    import tx_arb_pkg::*;

    logic [LEN_W-1:0] headDb;
    logic [LEN_W-1:0] headTc;
    logic             emptyDb;
    logic             emptyTc;
    logic             fullDb;
    logic             fullTc;
    logic             grantDb;
    logic             grantTc;
    src_t             rrLast;
    src_t             rrLastNext;

    req_queue #(.WIDTH(LEN_W), .DEPTH(QDEPTH)) uQueueDb (
        .clk      (clk),
        .reset    (reset),
        .push     (txStart_db),
        .pushData (txByteTotal_db),
        .pop      (grantDb),
        .head     (headDb),
        .empty    (emptyDb),
        .full     (fullDb)
    );

    req_queue #(.WIDTH(LEN_W), .DEPTH(QDEPTH)) uQueueTc (
        .clk      (clk),
        .reset    (reset),
        .push     (txStart_tc),
        .pushData (txByteTotal_tc),
        .pop      (grantTc),
        .head     (headTc),
        .empty    (emptyTc),
        .full     (fullTc)
    );

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        grantDb    = 1'b0;
        grantTc    = 1'b0;
        rrLastNext = rrLast;
        if (!tfFifoFull) begin
            if (!emptyDb && (emptyTc || rrLast == SRC_TC)) begin
                grantDb    = 1'b1;
                rrLastNext = SRC_DB;
            end else if (!emptyTc) begin
                grantTc    = 1'b1;
                rrLastNext = SRC_TC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rrLast    <= SRC_TC;
            tfWrEn    <= 1'b0;
            tfFifoIn  <= '0;
            frames_db <= '0;
            frames_tc <= '0;
        end else begin
            rrLast <= rrLastNext;
            tfWrEn <= grantDb || grantTc;
            if (grantDb) begin
                tfFifoIn  <= {SRC_DB, headDb};
                frames_db <= frames_db + 16'd1;
            end else if (grantTc) begin
                tfFifoIn  <= {SRC_TC, headTc};
                frames_tc <= frames_tc + 16'd1;
            end
        end
    end

    // A descriptor is lost only when its queue is full and nothing pops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_db <= 1'b0;
            ovf_tc <= 1'b0;
        end else begin
            if (txStart_db && fullDb && !grantDb) ovf_db <= 1'b1;
            if (txStart_tc && fullTc && !grantTc) ovf_tc <= 1'b1;
        end
    end

    assign busy = !emptyDb || !emptyTc || tfWrEn;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench: vector table plus hand sequences, writes scored against a queue.
module tb_tx_frame_arbiter;

    logic        clk;
    logic        reset;
    logic        txStart_db;
    logic [10:0] txByteTotal_db;
    logic        txStart_tc;
    logic [10:0] txByteTotal_tc;
    logic        tfFifoFull;
    logic [11:0] tfFifoIn;
    logic        tfWrEn;
    logic        ovf_db;
    logic        ovf_tc;
    logic [15:0] frames_db;
    logic [15:0] frames_tc;
    logic        busy;

    int nChecks = 0;
    int nFails  = 0;
    logic [11:0] expQ [$];

    typedef struct {
        logic        doDb;
        logic        doTc;
        logic [10:0] lenDb;
        logic [10:0] lenTc;
        int          nExp;
        logic [11:0] exp0;
        logic [11:0] exp1;
    } vec_t;

    vec_t vecs [7];

    tx_frame_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .txStart_db     (txStart_db),
        .txByteTotal_db (txByteTotal_db),
        .txStart_tc     (txStart_tc),
        .txByteTotal_tc (txByteTotal_tc),
        .tfFifoFull     (tfFifoFull),
        .tfFifoIn       (tfFifoIn),
        .tfWrEn         (tfWrEn),
        .ovf_db         (ovf_db),
        .ovf_tc         (ovf_tc),
        .frames_db      (frames_db),
        .frames_tc      (frames_tc),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and score any write seen there.
    task automatic step();
        logic [11:0] e;
        @(negedge clk);
        if (tfWrEn === 1'b1) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpectedWrite: got tfFifoIn 0x%0h with none expected", tfFifoIn);
            end else begin
                e = expQ.pop_front();
                check("tfFifoIn", 32'(tfFifoIn), 32'(e));
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drainLeft", 32'(expQ.size()), 32'd0);
    endtask

    task automatic doReset();
        reset      = 1'b1;
        txStart_db = 1'b0;
        txStart_tc = 1'b0;
        tfFifoFull = 1'b0;
        step();
        reset = 1'b0;
        expQ.delete();
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_tfFifoIn"},  32'(tfFifoIn),  32'd0);
        check({tag, "_tfWrEn"},    32'(tfWrEn),    32'd0);
        check({tag, "_ovf_db"},    32'(ovf_db),    32'd0);
        check({tag, "_ovf_tc"},    32'(ovf_tc),    32'd0);
        check({tag, "_frames_db"}, 32'(frames_db), 32'd0);
        check({tag, "_frames_tc"}, 32'(frames_tc), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 11'd100,  11'd200,  2, 12'h864, 12'h0C8};
        vecs[1] = '{1'b1, 1'b0, 11'd0,    11'd0,    1, 12'h800, 12'h000};
        vecs[2] = '{1'b1, 1'b1, 11'h7FF,  11'h7FF,  2, 12'h7FF, 12'hFFF};
        vecs[3] = '{1'b0, 1'b1, 11'd0,    11'd5,    1, 12'h005, 12'h000};
        vecs[4] = '{1'b1, 1'b1, 11'd1,    11'd2,    2, 12'h801, 12'h002};
        vecs[5] = '{1'b0, 1'b1, 11'd0,    11'h400,  1, 12'h400, 12'h000};
        vecs[6] = '{1'b1, 1'b1, 11'd3,    11'd4,    2, 12'h803, 12'h004};

        reset          = 1'b1;
        txStart_db     = 1'b0;
        txStart_tc     = 1'b0;
        txByteTotal_db = '0;
        txByteTotal_tc = '0;
        tfFifoFull     = 1'b0;
        step();
        step();
        checkIdle("reset");
        reset = 1'b0;

        // Vector table; tie order follows the round-robin history of earlier rows.
        for (int i = 0; i < 7; i++) begin
            txStart_db     = vecs[i].doDb;
            txByteTotal_db = vecs[i].lenDb;
            txStart_tc     = vecs[i].doTc;
            txByteTotal_tc = vecs[i].lenTc;
            expQ.push_back(vecs[i].exp0);
            if (vecs[i].nExp == 2) expQ.push_back(vecs[i].exp1);
            step();
            txStart_db = 1'b0;
            txStart_tc = 1'b0;
            step();
            check($sformatf("vec%0d_wr0", i), 32'(tfWrEn), 32'd1);
            if (vecs[i].nExp == 2) begin
                step();
                check($sformatf("vec%0d_wr1", i), 32'(tfWrEn), 32'd1);
            end
            step();
            check($sformatf("vec%0d_idleWr", i), 32'(tfWrEn), 32'd0);
            check($sformatf("vec%0d_idleBusy", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d_pending", i), 32'(expQ.size()), 32'd0);
        end
        check("table_frames_db", 32'(frames_db), 32'd5);
        check("table_frames_tc", 32'(frames_tc), 32'd6);

        // Single db frame: two-cycle latency.
        doReset();
        txStart_db     = 1'b1;
        txByteTotal_db = 11'd64;
        expQ.push_back(12'h840);
        step();
        txStart_db = 1'b0;
        check("lat_n1_wr", 32'(tfWrEn), 32'd0);
        check("lat_n1_busy", 32'(busy), 32'd1);
        step();
        check("lat_n2_wr", 32'(tfWrEn), 32'd1);
        check("lat_n2_frames_db", 32'(frames_db), 32'd1);
        step();
        check("lat_n3_wr", 32'(tfWrEn), 32'd0);

        // Backpressure then release: six back-to-back alternating writes.
        doReset();
        tfFifoFull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            txStart_db     = 1'b1;
            txByteTotal_db = 11'(10 + k);
            txStart_tc     = 1'b1;
            txByteTotal_tc = 11'(20 + k);
            expQ.push_back({1'b1, 11'(10 + k)});
            expQ.push_back({1'b0, 11'(20 + k)});
            step();
        end
        txStart_db = 1'b0;
        txStart_tc = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("bp_hold_wr", 32'(tfWrEn), 32'd0);
        end
        check("bp_hold_busy", 32'(busy), 32'd1);
        tfFifoFull = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("bp_burst%0d_wr", k), 32'(tfWrEn), 32'd1);
        end
        step();
        check("bp_after_wr", 32'(tfWrEn), 32'd0);
        check("bp_pending", 32'(expQ.size()), 32'd0);
        check("bp_frames_db", 32'(frames_db), 32'd3);
        check("bp_frames_tc", 32'(frames_tc), 32'd3);

        // Overflow: fifth tc descriptor into a full queue is lost.
        doReset();
        tfFifoFull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            txStart_tc     = 1'b1;
            txByteTotal_tc = 11'(30 + k);
            if (k < 4) expQ.push_back({1'b0, 11'(30 + k)});
            step();
            if (k == 3) check("ovf_before", 32'(ovf_tc), 32'd0);
        end
        txStart_tc = 1'b0;
        check("ovf_tc_set", 32'(ovf_tc), 32'd1);
        check("ovf_db_clear", 32'(ovf_db), 32'd0);
        tfFifoFull = 1'b0;
        drain(20);
        step();
        step();
        check("ovf_frames_tc", 32'(frames_tc), 32'd4);
        check("ovf_tc_sticky", 32'(ovf_tc), 32'd1);

        // Push into a full tc queue in the same cycle it is granted.
        doReset();
        tfFifoFull = 1'b1;
        for (int k = 0; k < 4; k++) begin
            txStart_tc     = 1'b1;
            txByteTotal_tc = 11'(40 + k);
            expQ.push_back({1'b0, 11'(40 + k)});
            step();
        end
        txByteTotal_tc = 11'd44;
        tfFifoFull     = 1'b0;
        expQ.push_back(12'h02C);
        step();
        txStart_tc = 1'b0;
        drain(20);
        step();
        check("pp_ovf_tc", 32'(ovf_tc), 32'd0);
        check("pp_frames_tc", 32'(frames_tc), 32'd5);

        // Reset while both queues hold descriptors.
        doReset();
        tfFifoFull = 1'b1;
        for (int k = 0; k < 2; k++) begin
            txStart_db     = 1'b1;
            txByteTotal_db = 11'(50 + k);
            txStart_tc     = 1'b1;
            txByteTotal_tc = 11'(60 + k);
            step();
        end
        txStart_db = 1'b0;
        txStart_tc = 1'b0;
        step();
        check("mr_busy_before", 32'(busy), 32'd1);
        reset      = 1'b1;
        tfFifoFull = 1'b0;
        step();
        reset = 1'b0;
        checkIdle("midReset");
        for (int k = 0; k < 5; k++) begin
            step();
            check("mr_no_wr", 32'(tfWrEn), 32'd0);
        end
        check("mr_busy_after", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Schedules transmit-frame descriptors from the two frame producers, the data hash generator (db) and the tree cache controller (tc), into the Ethernet controller's transmit frame-info FIFO. Each `txStart` pulse is queued per source. Pending frames are granted round-robin while the frame-info FIFO has room, and each grant becomes one `{src, byteTotal}` write. It sits in the top level between `hashGen`/`treeCacheCtrl` and `etherCtrl`, and replaces the inline two-source priority logic. It does not drop a descriptor unless a queue overflows.

## Interface
- `LEN_W`, 11: byte-total width.
- `QDEPTH`, 4: pending-descriptor queue depth per source; power of 2, at least 2.
- `clk` in 1: system clock (100 MHz domain).
- `reset` in 1: synchronous, active-high.
- `txStart_db` in 1: one-cycle frame-ready pulse from the hash generator.
- `txByteTotal_db` in LEN_W: frame length; valid with `txStart_db`.
- `txStart_tc` in 1: one-cycle frame-ready pulse from the tree cache controller.
- `txByteTotal_tc` in LEN_W: frame length; valid with `txStart_tc`.
- `tfFifoFull` in 1: frame-info FIFO programmable-full. It is asserted with at least 1 free entry remaining.
- `tfFifoIn` out LEN_W+1: `{src, byteTotal}`; src is 1 for db and 0 for tc.
- `tfWrEn` out 1: write strobe for `tfFifoIn`.
- `ovf_db`, `ovf_tc` out 1: sticky queue-overflow flags.
- `frames_db`, `frames_tc` out 16: granted-frame counters; they wrap at 2^16.
- `busy` out 1: high when any queue is non-empty or `tfWrEn` is high.

## Operation
- **Enqueue.** A `txStart_x` pulse pushes `txByteTotal_x` into queue x. Both sources may pulse in the same cycle; both descriptors are enqueued.
- **Decision cycle.** The arbiter is eligible when `tfFifoFull`=0.
  - One queue non-empty: grant that queue.
  - Both queues non-empty: grant the source other than `rr_last`.
  - `rr_last` resets to tc, so db wins the first tie.
- **Grant.** A grant pops the head of the granted queue and registers `tfFifoIn`={src, len} and `tfWrEn`=1 on the next edge. It also increments that source's frame counter and updates `rr_last`.
- **Rate.** At most one grant per cycle. With both queues loaded and the FIFO never full, grants alternate db, tc, db, ...
- **Queue full.**
  - Enqueue on a full queue while the same queue is popped that cycle: accepted, no overflow.
  - Enqueue on a full queue with no pop: the new descriptor is dropped and `ovf_x` is set.
  - `ovf_x` clears only on reset.
- **Zero-length descriptors** are forwarded unchanged. No length checking is done here.
- **Reset.** Reset at any time, including while queues are non-empty, synchronously empties both queues and drops their contents. Reset values:
  - `tfFifoIn`=0, `tfWrEn`=0
  - `ovf_db`=`ovf_tc`=0
  - `frames_db`=`frames_tc`=0
  - `busy`=0
  - `rr_last`=tc

## Timing
- A `txStart` in cycle N (sampled at the end of N) gives a non-empty queue in N+1, which is the decision cycle. `tfWrEn` and `tfFifoIn` are valid in N+2. Minimum latency is 2 cycles with no bypass path.
- `tfWrEn` is a single-cycle pulse per grant. Back-to-back grants give consecutive `tfWrEn` cycles.
- `tfFifoFull` is sampled only in the decision cycle. A write already registered still issues in the following cycle, which the 1-entry programmable-full slack covers.
- Counters update in the same cycle `tfWrEn` is asserted.

## Structure
- Package `tx_arb_pkg` holds:
  - `SRC_DB`=1'b1, `SRC_TC`=1'b0
  - default `LEN_W`=11
  - `TF_W`=`LEN_W`+1
  - the `src_t` enum.
- Sub-module `req_queue`, instantiated twice: a synchronous FIFO of width `LEN_W` and depth `QDEPTH`, with push, pop, head, empty, full and same-cycle push+pop support.
- The arbiter, output register, counters and sticky flags live in the top module.

## Test plan
- **Single db frame.** `txStart_db` with len 64 in cycle 10 → `tfWrEn`=1 and `tfFifoIn`=0x840 in cycle 12; `frames_db`=1.
- **Simultaneous requests.** `txStart_db` len 100 and `txStart_tc` len 200 in the same cycle → `tfFifoIn`=0x864 (db), then 0x0C8 (tc) on consecutive cycles.
- **Backpressure.** Hold `tfFifoFull`=1 with 3 db and 3 tc pending → no `tfWrEn`. Release → 6 back-to-back writes alternating db/tc, starting with db.
- **Overflow.** 5 `txStart_tc` pulses with `tfFifoFull`=1, `QDEPTH`=4 → `ovf_tc`=1, 4 descriptors later emitted, 5th lost; `ovf_db` stays 0.
- **Full-queue push+pop.** Push to a full tc queue in the same cycle it is granted → no overflow; all descriptors emitted in order.
- **Mid-operation reset.** Assert `reset` for 1 cycle with 2 pending per queue → no further `tfWrEn`; all outputs and counters are 0 and `busy`=0 the cycle after reset.
